// File: rtl/joy_db15_if.sv
// Pin-level bundle between the SNAC DB15 device model and its receiver/stimulus side.
interface joy_db15_if #(
    parameter int unsigned PBITS = 12
);
    logic [PBITS-1:0] joy1;
    logic [PBITS-1:0] joy2;
    logic             JOY_CLK;
    logic             JOY_LOAD;
    logic             JOY_DATA;
    logic             frame_done;
    logic [4:0]       bit_cnt;
    logic             overrun;

    modport master (
        output joy1, joy2, JOY_CLK, JOY_LOAD,
        input  JOY_DATA, frame_done, bit_cnt, overrun
    );

    modport slave (
        input  joy1, joy2, JOY_CLK, JOY_LOAD,
        output JOY_DATA, frame_done, bit_cnt, overrun
    );
endinterface

// File: rtl/joy_db15.sv
// Device-side SNAC DB15 adapter: parallel-load two joystick words, then shift them
// out active-low on JOY_DATA, one bit per synchronized JOY_CLK rising edge.
module joy_db15_dev #(
    parameter int unsigned FRAME_BITS  = 24,
    parameter int unsigned PBITS       = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    joy_db15_if.slave   jif
);
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                 state_q, state_nxt;
    logic [SYNC_STAGES-1:0] clk_sync, load_sync;
    logic                   clk_prev;
    logic [FRAME_BITS-1:0]  sreg_q, sreg_nxt;
    logic [CW-1:0]          cnt_q, cnt_nxt;
    logic                   data_q, data_nxt;
    logic                   done_q, done_nxt;
    logic                   ovr_q, ovr_nxt;

    logic                   clk_s_c, load_s_c, clk_rise_c;
    logic [FRAME_BITS-1:0]  frame_v_c;

    // Synchronizers idle high so a reset never looks like a load or a clock edge
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '1;
            load_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], jif.JOY_CLK};
            load_sync <= {load_sync[SYNC_STAGES-2:0], jif.JOY_LOAD};
            clk_prev  <= clk_s_c;
        end
    end

    assign clk_s_c    = clk_sync[SYNC_STAGES-1];
    assign load_s_c   = load_sync[SYNC_STAGES-1];
    assign clk_rise_c = clk_s_c & ~clk_prev;
    // Unused upper frame bits read back as released (1)
    assign frame_v_c  = ~FRAME_BITS'({PBITS'(jif.joy2), PBITS'(jif.joy1)});

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sreg_q  <= '1;
            cnt_q   <= '0;
            data_q  <= 1'b1;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            sreg_q  <= sreg_nxt;
            cnt_q   <= cnt_nxt;
            data_q  <= data_nxt;
            done_q  <= done_nxt;
            ovr_q   <= ovr_nxt;
        end
    end

    // Load level has priority over everything, including a coincident clock edge
    always_comb begin
        state_nxt = state_q;
        sreg_nxt  = sreg_q;
        cnt_nxt   = cnt_q;
        data_nxt  = data_q;
        done_nxt  = 1'b0;
        ovr_nxt   = ovr_q;
        if (!load_s_c) begin
            state_nxt = LOAD;
            sreg_nxt  = frame_v_c;
            cnt_nxt   = '0;
            data_nxt  = frame_v_c[0];
            ovr_nxt   = 1'b0;
        end else begin
            case (state_q)
                IDLE: data_nxt = 1'b1;
                LOAD: state_nxt = SHIFT;
                SHIFT: begin
                    if (clk_rise_c) begin
                        sreg_nxt = {1'b1, sreg_q[FRAME_BITS-1:1]};
                        cnt_nxt  = cnt_q + CW'(1);
                        data_nxt = sreg_q[1];
                        if (cnt_q + CW'(1) == CW'(FRAME_BITS)) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                            data_nxt  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    data_nxt = 1'b1;
                    if (clk_rise_c) ovr_nxt = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign jif.JOY_DATA   = data_q;
    assign jif.frame_done = done_q;
    assign jif.bit_cnt    = cnt_q;
    assign jif.overrun    = ovr_q;
endmodule

// File: tb/tb_joy_db15_dev.sv
// Bench for joy_db15_dev: frame table plus scoreboard of expected serial bits.
module tb_joy_db15_dev;
    logic clk_sys = 1'b0;
    logic reset_n;

    joy_db15_if #(.PBITS(12)) jif ();

    joy_db15_dev #(.FRAME_BITS(24), .PBITS(12), .SYNC_STAGES(2)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .jif     (jif)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [11:0] j1;
        logic [11:0] j2;
        logic [23:0] stream;
    } vec_t;

    vec_t vecs[5];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    logic q_bits[$];

    always @(negedge clk_sys) if (jif.frame_done === 1'b1) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_clk();
        jif.JOY_CLK = 1'b1;
        tick(8);
        jif.JOY_CLK = 1'b0;
        tick(8);
    endtask

    task automatic start_load(input logic [11:0] j1, input logic [11:0] j2, input logic [23:0] stream);
        jif.joy1     = j1;
        jif.joy2     = j2;
        jif.JOY_LOAD = 1'b0;
        tick(4);
        jif.JOY_LOAD = 1'b1;
        tick(4);
        for (int i = 0; i < 24; i++) q_bits.push_back(stream[i]);
    endtask

    // Compare the pre-edge bit against the scoreboard, then apply one JOY_CLK period
    task automatic do_edges(input int n);
        logic exp;
        for (int i = 0; i < n; i++) begin
            if (q_bits.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got no expected bit, required one queued");
            end else begin
                exp = q_bits.pop_front();
                chk($sformatf("data_bit_pre_edge%0d", i), 32'(jif.JOY_DATA), 32'(exp));
            end
            pulse_clk();
        end
    endtask

    task automatic check_frame_end(input int d0, input string tag);
        chk({tag, "_frame_done_once"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_bit_cnt"}, 32'(jif.bit_cnt), 32'd24);
        chk({tag, "_data_idle"}, 32'(jif.JOY_DATA), 32'd1);
        chk({tag, "_sb_drained"}, 32'(q_bits.size()), 32'd0);
    endtask

    initial begin
        int d0;
        logic exp;

        vecs[0] = '{12'h015, 12'hA00, 24'h5FFFEA};
        vecs[1] = '{12'h000, 12'h000, 24'hFFFFFF};
        vecs[2] = '{12'hFFF, 12'hFFF, 24'h000000};
        vecs[3] = '{12'h001, 12'h800, 24'h7FFFFE};
        vecs[4] = '{12'h123, 12'h456, 24'hBA9EDC};

        // Reset with load held low
        reset_n      = 1'b0;
        jif.JOY_CLK  = 1'b0;
        jif.JOY_LOAD = 1'b0;
        jif.joy1     = 12'h001;
        jif.joy2     = 12'h000;
        tick(3);
        chk("rst_data", 32'(jif.JOY_DATA), 32'd1);
        chk("rst_bit_cnt", 32'(jif.bit_cnt), 32'd0);
        chk("rst_frame_done", 32'(jif.frame_done), 32'd0);
        chk("rst_overrun", 32'(jif.overrun), 32'd0);
        reset_n = 1'b1;
        tick(3);
        chk("rst_to_load_data", 32'(jif.JOY_DATA), 32'd0);
        chk("rst_to_load_cnt", 32'(jif.bit_cnt), 32'd0);
        jif.JOY_LOAD = 1'b1;
        tick(4);

        // Table of full frames
        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt;
            start_load(vecs[v].j1, vecs[v].j2, vecs[v].stream);
            do_edges(24);
            check_frame_end(d0, $sformatf("vec%0d", v));
        end

        // Overrun: edges 25 and 26 after the last frame
        chk("ovr_before", 32'(jif.overrun), 32'd0);
        pulse_clk();
        chk("ovr_edge25", 32'(jif.overrun), 32'd1);
        chk("ovr_edge25_data", 32'(jif.JOY_DATA), 32'd1);
        chk("ovr_edge25_cnt", 32'(jif.bit_cnt), 32'd24);
        pulse_clk();
        chk("ovr_edge26", 32'(jif.overrun), 32'd1);
        chk("ovr_edge26_cnt", 32'(jif.bit_cnt), 32'd24);
        jif.JOY_LOAD = 1'b0;
        tick(4);
        chk("ovr_cleared", 32'(jif.overrun), 32'd0);
        chk("ovr_cnt_cleared", 32'(jif.bit_cnt), 32'd0);
        jif.JOY_LOAD = 1'b1;
        tick(4);

        // Mid-frame reload aborts without frame_done
        d0 = done_cnt;
        start_load(12'h123, 12'h456, 24'hBA9EDC);
        do_edges(7);
        q_bits.delete();
        jif.joy1     = 12'h001;
        jif.JOY_LOAD = 1'b0;
        tick(3);
        chk("abort_data", 32'(jif.JOY_DATA), 32'd0);
        chk("abort_cnt", 32'(jif.bit_cnt), 32'd0);
        tick(1);
        jif.JOY_LOAD = 1'b1;
        tick(4);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        d0 = done_cnt;
        start_load(12'h001, 12'h456, 24'hBA9FFE);
        do_edges(24);
        check_frame_end(d0, "after_abort");

        // Clock rise and load fall at the same pin instant: load wins
        d0 = done_cnt;
        start_load(12'h001, 12'h000, 24'hFFFFFE);
        jif.JOY_CLK  = 1'b1;
        jif.JOY_LOAD = 1'b0;
        tick(4);
        chk("simul_cnt", 32'(jif.bit_cnt), 32'd0);
        chk("simul_data", 32'(jif.JOY_DATA), 32'd0);
        jif.JOY_CLK = 1'b0;
        tick(2);
        jif.JOY_LOAD = 1'b1;
        tick(4);
        do_edges(24);
        check_frame_end(d0, "simul");

        // Input change mid-shift keeps the snapshot
        d0 = done_cnt;
        start_load(12'h000, 12'h000, 24'hFFFFFF);
        do_edges(3);
        jif.joy1 = 12'hFFF;
        do_edges(21);
        check_frame_end(d0, "snapshot");

        // Latency and one-cycle clock glitch
        d0 = done_cnt;
        start_load(12'h002, 12'h000, 24'hFFFFFD);
        exp = q_bits.pop_front();
        chk("lat_pre", 32'(jif.JOY_DATA), 32'(exp));
        jif.JOY_CLK = 1'b1;
        tick(1);
        jif.JOY_CLK = 1'b0;
        tick(1);
        chk("lat_2cyc", 32'(jif.JOY_DATA), 32'd1);
        tick(1);
        chk("lat_3cyc", 32'(jif.JOY_DATA), 32'd0);
        chk("lat_cnt", 32'(jif.bit_cnt), 32'd1);
        tick(10);
        chk("glitch_once", 32'(jif.bit_cnt), 32'd1);
        do_edges(23);
        check_frame_end(d0, "latency");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
